// File: rtl/clct_drift_latch_cclut_pkg.sv
// Shared definitions for the ccLUT drift latch.
// Contents:
//   - widths: MXPATB, MXKEYBX, MXPATC, MXDRIFT, MXDEAD, MXCNT
//   - pattern field offsets: NHITS_MSB/LSB, PID_MSB/LSB
//   - state_t: IDLE=0, DRIFT=1, DEAD=2
//   - cand_t: one candidate {pat, key, carry}
package clct_drift_latch_cclut_pkg;

  localparam int MXPATB  = 6;
  localparam int MXKEYBX = 8;
  localparam int MXPATC  = 11;
  localparam int MXDRIFT = 2;
  localparam int MXDEAD  = 4;
  localparam int MXCNT   = 16;

  localparam int NHITS_MSB = 5;
  localparam int NHITS_LSB = 3;
  localparam int PID_MSB   = 2;
  localparam int PID_LSB   = 0;

  // One down-counter serves both the drift and the dead windows.
  localparam int CNTW = (MXDEAD > MXDRIFT) ? MXDEAD : MXDRIFT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIFT = 2'd1,
    DEAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MXPATB-1:0]  pat;
    logic [MXKEYBX-1:0] key;
    logic [MXPATC-1:0]  carry;
  } cand_t;

endpackage

// File: rtl/clct_drift_latch_cclut_if.sv
// Candidate-in / CLCT-out bus of the drift latch.
// Signals:
//   in_vld, best_pat, best_key, best_carry : selector output into the latch
//   clct_vld, clct_pat, clct_key, clct_carry : latched CLCT out of the latch
// Handshake: there is no ready. in_vld qualifies best_* for the single clock
// it is high. clct_vld is a one-clock strobe with no backpressure; clct_*
// stay stable until the next strobe.
// Modports: master = selector/bench side, slave = latch side.
interface clct_drift_latch_cclut_if;
  import clct_drift_latch_cclut_pkg::*;

  logic               in_vld;
  logic [MXPATB-1:0]  best_pat;
  logic [MXKEYBX-1:0] best_key;
  logic [MXPATC-1:0]  best_carry;

  logic               clct_vld;
  logic [MXPATB-1:0]  clct_pat;
  logic [MXKEYBX-1:0] clct_key;
  logic [MXPATC-1:0]  clct_carry;

  modport master (
    output in_vld, best_pat, best_key, best_carry,
    input  clct_vld, clct_pat, clct_key, clct_carry
  );

  modport slave (
    input  in_vld, best_pat, best_key, best_carry,
    output clct_vld, clct_pat, clct_key, clct_carry
  );

endinterface

// File: rtl/clct_drift_latch_cclut_cand_compare.sv
// Combinational better(held, input) for ccLUT candidates.
// Ports:
//   held_i     : currently held candidate
//   cand_i     : new candidate
//   cand_vld_i : new candidate present
//   best_o     : winner
// The sort key is pat[5:1]; the bend-direction lsb does not rank. The new
// candidate wins only on a strictly greater key, so the earlier one keeps
// ties. Also intended for the later two-CLCT logic.
module clct_drift_latch_cclut_cand_compare
  import clct_drift_latch_cclut_pkg::*;
(
  input  cand_t held_i,
  input  cand_t cand_i,
  input  logic  cand_vld_i,
  output cand_t best_o
);

  logic cand_better;

  assign cand_better = cand_vld_i &&
    (cand_i.pat[NHITS_MSB:PID_LSB+1] > held_i.pat[NHITS_MSB:PID_LSB+1]);

  assign best_o = cand_better ? cand_i : held_i;

endmodule

// File: rtl/clct_drift_latch_cclut.sv
// Drift latch behind the ccLUT best-1-of-5 selector.
// Pre-triggers on a candidate passing the hit/pid thresholds, keeps the best
// candidate over drift_delay further clocks, emits one CLCT, then ignores
// input for dead_time clocks.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   bus (slave)             : candidate in, latched CLCT out
//   hit_thresh, pid_thresh  : pre-trigger thresholds
//   drift_delay, dead_time  : window lengths, sampled when the counter loads
//   cnt_clr                 : clears clct_cnt, wins over a coincident emit
//   pretrig, busy, clct_cnt : status outputs (all registered)
//   state_dbg               : current FSM state
module clct_drift_latch_cclut
  import clct_drift_latch_cclut_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  clct_drift_latch_cclut_if.slave bus,
  input  logic [2:0]         hit_thresh,
  input  logic [2:0]         pid_thresh,
  input  logic [MXDRIFT-1:0] drift_delay,
  input  logic [MXDEAD-1:0]  dead_time,
  input  logic               cnt_clr,
  output logic               pretrig,
  output logic               busy,
  output logic [MXCNT-1:0]   clct_cnt,
  output state_t             state_dbg
);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  cand_t             held_q, held_d;
  cand_t             clct_q, clct_d;
  logic              pretrig_q, pretrig_d;
  logic              clct_vld_q, clct_vld_d;
  logic              busy_q, busy_d;
  logic [MXCNT-1:0]  clct_cnt_q, clct_cnt_d;

  cand_t in_cand;
  cand_t merged;
  cand_t emit_cand;
  logic  emit;
  logic  qualify;

  assign in_cand = {bus.best_pat, bus.best_key, bus.best_carry};

  assign qualify = bus.in_vld &&
                   (bus.best_pat[NHITS_MSB:NHITS_LSB] >= hit_thresh) &&
                   (bus.best_pat[PID_MSB:PID_LSB] >= pid_thresh);

  clct_drift_latch_cclut_cand_compare u_cmp (
    .held_i     (held_q),
    .cand_i     (in_cand),
    .cand_vld_i (bus.in_vld),
    .best_o     (merged)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    pretrig_d = 1'b0;
    emit      = 1'b0;
    emit_cand = held_q;

    case (state_q)
      IDLE: begin
        if (qualify) begin
          pretrig_d = 1'b1;
          held_d    = in_cand;
          if (drift_delay == '0) begin
            emit      = 1'b1;
            emit_cand = in_cand;
          end else begin
            cnt_d   = CNTW'(drift_delay);
            state_d = DRIFT;
          end
        end
      end
      DRIFT: begin
        // Thresholds gate only the first candidate; in-window ones just rank.
        held_d = merged;
        if (cnt_q == CNTW'(1)) begin
          emit      = 1'b1;
          emit_cand = merged;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DEAD: begin
        if (cnt_q == CNTW'(1)) state_d = IDLE;
        else                   cnt_d   = cnt_q - CNTW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Every emit path ends the window the same way.
    if (emit) begin
      if (dead_time == '0) begin
        state_d = IDLE;
      end else begin
        state_d = DEAD;
        cnt_d   = CNTW'(dead_time);
      end
    end

    clct_vld_d = emit;
    clct_d     = emit ? emit_cand : clct_q;
    busy_d     = (state_d != IDLE);

    if (cnt_clr)                       clct_cnt_d = '0;
    else if (emit && (clct_cnt_q != '1)) clct_cnt_d = clct_cnt_q + MXCNT'(1);
    else                               clct_cnt_d = clct_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      held_q     <= '0;
      clct_q     <= '0;
      pretrig_q  <= 1'b0;
      clct_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      clct_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      clct_q     <= clct_d;
      pretrig_q  <= pretrig_d;
      clct_vld_q <= clct_vld_d;
      busy_q     <= busy_d;
      clct_cnt_q <= clct_cnt_d;
    end
  end

  assign bus.clct_vld   = clct_vld_q;
  assign bus.clct_pat   = clct_q.pat;
  assign bus.clct_key   = clct_q.key;
  assign bus.clct_carry = clct_q.carry;
  assign pretrig        = pretrig_q;
  assign busy           = busy_q;
  assign clct_cnt       = clct_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/clct_drift_latch_cclut.md
Name: clct_drift_latch_ccLUT

Overview:
- Sequential stage directly downstream of the ccLUT best-1-of-5 selector.
- Each clock it takes the selector's winning pattern, key and comparator code, and pre-triggers when the candidate passes the hit and pattern-id thresholds.
- It then tracks the best candidate over a programmable drift window, emits one latched CLCT with a valid strobe, and enforces programmable dead time.
- Output feeds the CLCT sequencer / readout FIFO.

Parameters:
- MXPATB, 6, pattern bits: {nhits[2:0], pid[2:0]}; pid lsb is bend direction
- MXKEYBX, 8, half-strip key bits
- MXPATC, 11, ccLUT comparator-code (carry) bits
- MXDRIFT, 2, drift_delay width
- MXDEAD, 4, dead_time width
- MXCNT, 16, CLCT counter width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous reset, active-low
- in_vld  in  1  best_* inputs valid this clock
- best_pat  in  MXPATB  pattern from the 1-of-5 selector
- best_key  in  MXKEYBX  key half-strip from the selector
- best_carry  in  MXPATC  comparator code from the selector
- hit_thresh  in  3  minimum nhits to pre-trigger
- pid_thresh  in  3  minimum pid to pre-trigger
- drift_delay  in  MXDRIFT  extra samples in the drift window
- dead_time  in  MXDEAD  samples ignored after emit
- cnt_clr  in  1  synchronous clear of clct_cnt
- pretrig  out  1  one-clock pulse on qualifying first candidate
- clct_vld  out  1  one-clock pulse, latched CLCT valid
- clct_pat  out  MXPATB  latched pattern
- clct_key  out  MXKEYBX  latched key
- clct_carry  out  MXPATC  latched comparator code
- busy  out  1  state != IDLE (registered)
- clct_cnt  out  MXCNT  saturating count of emitted CLCTs

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE; all outputs, held candidate and counters go to 0. Reset overrides everything, including mid-drift or mid-dead; no emit occurs.
- Qualify: in_vld && best_pat[5:3]>=hit_thresh && best_pat[2:0]>=pid_thresh.
- Sort key = pat[5:1]; the bend lsb is ignored. A later candidate replaces the held one only if its sort key is strictly greater, so earlier wins on ties.
- States:
  - IDLE: on a qualifying edge N, pretrig<=1 and held<=input.
    - If drift_delay==0, emit the input at N and go to DEAD (or IDLE if dead_time==0).
    - Otherwise cnt<=drift_delay and go to DRIFT.
  - DRIFT: each edge, merged = better(held, input if in_vld; the threshold is not applied), and held<=merged.
    - If cnt==1, emit merged and go to DEAD (or IDLE if dead_time==0).
    - Otherwise cnt--.
  - DEAD: inputs ignored, no pretrig. If cnt==1 go to IDLE, else cnt--.
- Emit: clct_vld<=1 for one clock and clct_pat/key/carry<=winner. clct_* hold their value until the next emit.
  - clct_cnt increments on emit and saturates at all-ones.
  - cnt_clr zeroes clct_cnt; cnt_clr wins over a simultaneous emit.
- Latency: a trigger sampled at edge N gives pretrig high after edge N and clct_vld high after edge N+drift_delay. The earliest next trigger is sampled at edge N+drift_delay+dead_time+1.
- drift_delay and dead_time are sampled only when the counter loads; changing them mid-window has no effect on the current window.
- pretrig and clct_vld coincide only when drift_delay==0.
- busy is high from the edge after the trigger through the last DEAD cycle.

Decomposition:
- Shared package holds:
  - pattern field offsets: NHITS_MSB=5, NHITS_LSB=3, PID_MSB=2, PID_LSB=0
  - MXPATB, MXKEYBX, MXPATC
  - state encoding: IDLE=0, DRIFT=1, DEAD=2
- One natural sub-module: clct_cand_compare, the combinational better(held, input) using the strict-greater pat[5:1] rule. It is reused by later two-CLCT logic.

Test Plan:
- Single trigger, drift=2, dead=0: pat=6'b100_010 at N, no further inputs -> pretrig after N; clct_vld after N+2 with pat=6'b100_010 and the same key/carry; clct_cnt=1.
- Better candidate in window, drift=2: N pat=6'b011_100 key=10; N+1 pat=6'b101_000 key=12 -> emit key=12. Repeat with a tie differing only in the lsb at N+1 -> key=10 kept.
- Thresholds hit=4, pid=2: pat=6'b011_110 -> no pretrig; pat=6'b100_001 -> no pretrig; pat=6'b100_010 -> pretrig.
- Dead time, drift=0, dead=3: qualifying input every clock from N -> emits at N, N+4 and N+8 only; busy high on the three DEAD cycles between emits.
- Reset mid-drift: drift=3, reset_n=0 at N+1 -> no clct_vld, state IDLE, all outputs 0. The next qualifying input triggers normally.
- Counter: force 0xFFFF emits -> clct_cnt holds 0xFFFF. cnt_clr on an emit edge -> clct_cnt=0.
